// File: rtl/line_window_buffer_if.sv
// Pixel-in / column-out bus of line_window_buffer.
// Valid/ready: a read transfers on a cycle where rd_req && rd_ready; in_valid and out_valid are
// plain strobes with no back-pressure. Every accepted read gives exactly one out_valid, one cycle later.
interface line_window_buffer_if #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int NUM_LINES = 6
);
  localparam int WIN    = NUM_LINES - 1;
  localparam int FILL_W = $clog2(NUM_LINES);

  logic                  sof;
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  rd_req;
  logic [ADDR_W-1:0]     rd_addr;
  logic                  rd_ready;
  logic                  out_valid;
  logic [WIN*DATA_W-1:0] out_window;
  logic                  line_done;
  logic [FILL_W-1:0]     lines_filled;

  modport master (
    output sof, in_valid, in_data, rd_req, rd_addr,
    input  rd_ready, out_valid, out_window, line_done, lines_filled
  );

  modport slave (
    input  sof, in_valid, in_data, rd_req, rd_addr,
    output rd_ready, out_valid, out_window, line_done, lines_filled
  );
endinterface

// File: rtl/line_window_buffer.sv
// Ring of NUM_LINES line memories; returns a NUM_LINES-1 tall column, oldest line in tap 0.
// Optional top-border replication at frame start: define LINE_WINDOW_BORDER_REPLICATE_EN.
module line_window_buffer #(
  parameter int DATA_W    = 8,
  parameter int LINE_LEN  = 640,
  parameter int ADDR_W    = 10,
  parameter int NUM_LINES = 6
) (
  input logic                clock,
  input logic                reset,
  line_window_buffer_if.slave bus
);
  localparam int WIN   = NUM_LINES - 1;
  localparam int PTR_W = $clog2(NUM_LINES);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(LINE_LEN - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(NUM_LINES - 1);
  localparam logic [PTR_W-1:0]  FULL     = PTR_W'(WIN);

  logic [DATA_W-1:0]     mem [NUM_LINES][LINE_LEN];
  logic [ADDR_W-1:0]     wcol;
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      fill;
  logic                  line_done_q;
  logic                  out_valid_q;
  logic [WIN*DATA_W-1:0] out_window_q;

  logic                  wrap;
  logic                  ready;
  logic                  rd_accept;
  logic [ADDR_W-1:0]     rd_col;
  logic [PTR_W-1:0]      wr_line;
  logic [ADDR_W-1:0]     wr_col;
  logic [PTR_W-1:0]      tap_line [WIN];

  assign wrap = bus.in_valid && (wcol == LAST_COL);

`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
  assign ready = (fill != '0);
`else
  assign ready = (fill == FULL);
`endif

  assign rd_accept = bus.rd_req && ready;
  // Out-of-range columns read column 0; their data is don't-care.
  assign rd_col  = (bus.rd_addr <= LAST_COL) ? bus.rd_addr : '0;
  assign wr_line = bus.sof ? '0 : wptr;
  assign wr_col  = bus.sof ? '0 : wcol;

  // Write-side pointers; sof restarts the frame and overrides any wrap in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      wcol        <= '0;
      wptr        <= '0;
      fill        <= '0;
      line_done_q <= 1'b0;
    end else begin
      line_done_q <= wrap && !bus.sof;
      if (bus.sof) begin
        wptr <= '0;
        fill <= '0;
        wcol <= bus.in_valid ? ADDR_W'(1) : '0;
      end else if (bus.in_valid) begin
        if (wrap) begin
          wcol <= '0;
          wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
          if (fill != FULL) fill <= fill + 1'b1;
        end else begin
          wcol <= wcol + 1'b1;
        end
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset && bus.in_valid) mem[wr_line][wr_col] <= bus.in_data;
  end

  // Tap k reads line wptr+1+k (mod NUM_LINES); the line being written is never a tap.
  always_comb begin
    int src;
    int idx;
    src = 0;
    idx = 0;
    for (int k = 0; k < WIN; k++) begin
      src = k;
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
      if (k < WIN - int'(fill)) src = WIN - int'(fill);
`endif
      idx = int'(wptr) + 1 + src;
      if (idx >= NUM_LINES) idx = idx - NUM_LINES;
      tap_line[k] = PTR_W'(idx);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
    end else begin
      out_valid_q <= rd_accept;
      if (rd_accept) begin
        for (int k = 0; k < WIN; k++)
          out_window_q[k*DATA_W +: DATA_W] <= mem[tap_line[k]][rd_col];
      end
    end
  end

  assign bus.rd_ready     = ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_window   = out_window_q;
  assign bus.line_done    = line_done_q;
  assign bus.lines_filled = fill;
endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer with 4-pixel lines and a 6-line ring (5 taps).
module tb_line_window_buffer;
  localparam int DATA_W    = 8;
  localparam int LINE_LEN  = 4;
  localparam int ADDR_W    = 2;
  localparam int NUM_LINES = 6;
  localparam int WIN       = NUM_LINES - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  line_window_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_LINES(NUM_LINES)) bus ();

  line_window_buffer #(
    .DATA_W(DATA_W), .LINE_LEN(LINE_LEN), .ADDR_W(ADDR_W), .NUM_LINES(NUM_LINES)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] win5(input int t0, input int t1, input int t2,
                                       input int t3, input int t4);
    logic [63:0] w;
    w = '0;
    w[39:0] = {t4[7:0], t3[7:0], t2[7:0], t1[7:0], t0[7:0]};
    return w;
  endfunction

  task automatic write_pixel(input int d);
    bus.in_valid = 1'b1;
    bus.in_data  = d[DATA_W-1:0];
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic write_line(input int base);
    for (int c = 0; c < LINE_LEN; c++) write_pixel(base + c);
  endtask

  task automatic read_col(input int col);
    bus.rd_req  = 1'b1;
    bus.rd_addr = col[ADDR_W-1:0];
    step();
    bus.rd_req  = 1'b0;
  endtask

  initial begin
    logic [63:0] held;
    bus.sof      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;

    // Reset state
    step();
    step();
    chk("reset_rd_ready", 64'(bus.rd_ready), 64'd0);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_window", 64'(bus.out_window), 64'd0);
    chk("reset_line_done", 64'(bus.line_done), 64'd0);
    chk("reset_lines_filled", 64'(bus.lines_filled), 64'd0);
    rst = 1'b0;

    // Three lines, then an early read
    write_line(0);
    write_line(10);
    write_line(20);
    chk("l2_line_done", 64'(bus.line_done), 64'd1);
    chk("l2_lines_filled", 64'(bus.lines_filled), 64'd3);
    step();
    chk("l2_line_done_drop", 64'(bus.line_done), 64'd0);
    read_col(0);
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
    chk("early_rd_ready", 64'(bus.rd_ready), 64'd1);
    chk("early_out_valid", 64'(bus.out_valid), 64'd1);
    chk("early_window", 64'(bus.out_window), win5(0, 0, 0, 10, 20));
`else
    chk("early_rd_ready", 64'(bus.rd_ready), 64'd0);
    chk("early_out_valid", 64'(bus.out_valid), 64'd0);
`endif

    // Fill to five lines and read column 2
    write_line(30);
    write_line(40);
    chk("full_lines_filled", 64'(bus.lines_filled), 64'd5);
    chk("full_rd_ready", 64'(bus.rd_ready), 64'd1);
    read_col(2);
    chk("col2_out_valid", 64'(bus.out_valid), 64'd1);
    chk("col2_window", 64'(bus.out_window), win5(2, 12, 22, 32, 42));
    held = 64'(bus.out_window);
    step();
    chk("idle_out_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_hold", 64'(bus.out_window), held);

    // Lines 5 and 6 push wptr past the end of the ring; back-to-back reads
    write_line(50);
    write_line(60);
    chk("sat_lines_filled", 64'(bus.lines_filled), 64'd5);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 2'd1;
    step();
    chk("col1_window", 64'(bus.out_window), win5(21, 31, 41, 51, 61));
    bus.rd_addr = 2'd3;
    step();
    bus.rd_req = 1'b0;
    chk("b2b_out_valid", 64'(bus.out_valid), 64'd1);
    chk("col3_window", 64'(bus.out_window), win5(23, 33, 43, 53, 63));

    // Last pixel of line 7 together with a read: pre-rotation taps, then rotated taps
    write_pixel(70);
    write_pixel(71);
    write_pixel(72);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd73;
    bus.rd_req   = 1'b1;
    bus.rd_addr  = 2'd0;
    step();
    bus.in_valid = 1'b0;
    chk("rot_pre_window", 64'(bus.out_window), win5(20, 30, 40, 50, 60));
    chk("rot_line_done", 64'(bus.line_done), 64'd1);
    step();
    bus.rd_req = 1'b0;
    chk("rot_post_window", 64'(bus.out_window), win5(30, 40, 50, 60, 70));
    chk("rot_line_done_pulse", 64'(bus.line_done), 64'd0);

    // sof with a pixel mid-line restarts the frame at line 0 column 0
    write_pixel(80);
    write_pixel(81);
    bus.sof = 1'b1;
    write_pixel(99);
    bus.sof = 1'b0;
    chk("sof_lines_filled", 64'(bus.lines_filled), 64'd0);
    chk("sof_rd_ready", 64'(bus.rd_ready), 64'd0);
    chk("sof_line_done", 64'(bus.line_done), 64'd0);
    write_pixel(1);
    write_pixel(2);
    write_pixel(3);
    write_line(10);
    write_line(20);
    write_line(30);
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
    chk("sof_four_rd_ready", 64'(bus.rd_ready), 64'd1);
`else
    chk("sof_four_rd_ready", 64'(bus.rd_ready), 64'd0);
`endif
    write_line(40);
    read_col(0);
    chk("sof_window", 64'(bus.out_window), win5(99, 10, 20, 30, 40));

    // Reset mid-line, then rebuild five lines
    write_pixel(50);
    write_pixel(51);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_out_window", 64'(bus.out_window), 64'd0);
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_lines_filled", 64'(bus.lines_filled), 64'd0);
    chk("mrst_rd_ready", 64'(bus.rd_ready), 64'd0);
    chk("mrst_line_done", 64'(bus.line_done), 64'd0);
    read_col(0);
    chk("mrst_read_ignored", 64'(bus.out_valid), 64'd0);
    write_line(100);
    write_line(110);
    write_line(120);
    write_line(130);
    read_col(1);
`ifdef LINE_WINDOW_BORDER_REPLICATE_EN
    chk("mrst_four_out_valid", 64'(bus.out_valid), 64'd1);
`else
    chk("mrst_four_out_valid", 64'(bus.out_valid), 64'd0);
`endif
    write_line(140);
    read_col(3);
    chk("mrst_five_out_valid", 64'(bus.out_valid), 64'd1);
    chk("mrst_five_window", 64'(bus.out_window), win5(103, 113, 123, 133, 143));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
